// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types for the DR access sequencer: transfer states,
// requester indices and the owner-to-one-hot decode.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        LOAD,
        DONE
    } dr_xfer_state_t;

    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_EXEC  = 1;

    // Owner is a single bit: 0 = fetch, 1 = execute.
    function automatic logic [1:0] owner_onehot(input logic owner);
        logic [1:0] oh;
        oh            = '0;
        oh[REQ_FETCH] = ~owner;
        oh[REQ_EXEC]  = owner;
        return oh;
    endfunction

endpackage

// File: rtl/dr_access_ctrl_rr_arb2.sv
// Two-way combinational round-robin pick: a lone request always wins,
// a tie goes to the requester named by rr_ptr.
module rr_arb2
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] pick
);

    always_comb begin
        pick            = '0;
        pick[REQ_FETCH] = req[REQ_FETCH] & (~req[REQ_EXEC]  | ~rr_ptr);
        pick[REQ_EXEC]  = req[REQ_EXEC]  & (~req[REQ_FETCH] |  rr_ptr);
    end

endmodule

// File: rtl/dr_access_ctrl.sv
// Sequences memory reads into the 8-bit DR for the fetch and execute
// requesters; all outputs are registered and decoded from the next state.
module dr_access_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_rdy,
    output logic              bus_mem_oe,
    output logic              drload
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    dr_xfer_state_t    state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              mem_rd_q, mem_rd_d;
    logic              oe_q, oe_d;
    logic              drload_q, drload_d;
    logic [1:0]        pick;

    rr_arb2 u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = ADDR;
                    owner_d    = pick[REQ_EXEC];
                    mem_addr_d = pick[REQ_EXEC] ? addr1 : addr0;
                end
            end
            ADDR: state_d = WAIT;
            WAIT: begin
                if (mem_rdy) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Compare before incrementing so the counter stops at TIMEOUT.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: state_d = DONE;
            DONE: begin
                rr_ptr_d = ~owner_q;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Moore outputs decoded from the state being entered, then registered.
        busy_d   = (state_d != IDLE);
        gnt_d    = (state_d != IDLE) ? owner_onehot(owner_d) : '0;
        done_d   = (state_d == DONE) ? owner_onehot(owner_d) : '0;
        mem_rd_d = (state_d == ADDR) || (state_d == WAIT) || (state_d == LOAD);
        oe_d     = (state_d == LOAD);
        drload_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            oe_q       <= 1'b0;
            drload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            mem_rd_q   <= mem_rd_d;
            oe_q       <= oe_d;
            drload_q   <= drload_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign bus_mem_oe = oe_q;
    assign drload     = drload_q;

endmodule

// File: tb/tb_dr_access_ctrl.sv
// Directed bench for dr_access_ctrl; a negedge-clocked DR register
// captures bus[7:0] whenever drload and bus_mem_oe are high.
module tb_dr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] addr0 = 16'h0000;
    logic [15:0] addr1 = 16'h0000;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_rdy = 1'b0;
    logic        bus_mem_oe;
    logic        drload;

    logic [15:0] bus_val = 16'h0000;
    logic [7:0]  dr = 8'h00;

    int compared   = 0;
    int mismatched = 0;

    dr_access_ctrl #(.ADDR_W(16), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr0      (addr0),
        .addr1      (addr1),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdy    (mem_rdy),
        .bus_mem_oe (bus_mem_oe),
        .drload     (drload)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drload && bus_mem_oe) dr <= bus_val[7:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        compared++;
        if ({gnt, done, err, busy, mem_rd, bus_mem_oe, drload} !== 9'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b expected 000000000",
                     {gnt, done, err, busy, mem_rd, bus_mem_oe, drload});
        end
        compared++;
        if (mem_addr !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr);
        end
        rst = 1'b0;
        tick();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        req = 2'b01; addr0 = 16'h0012; addr1 = 16'h0034;
        mem_rdy = 1'b1; bus_val = 16'hBEA5;
        tick();  // ADDR
        req = 2'b00;
        compared++;
        if (mem_addr !== 16'h0012) begin
            mismatched++;
            $display("FAIL basic_mem_addr: got %h expected 0012", mem_addr);
        end
        compared++;
        if ({gnt, busy, mem_rd, drload} !== 5'b01110) begin
            mismatched++;
            $display("FAIL basic_addr_state: got %b expected 01110", {gnt, busy, mem_rd, drload});
        end
        tick();  // WAIT
        compared++;
        if ({mem_rd, drload, bus_mem_oe} !== 3'b100) begin
            mismatched++;
            $display("FAIL basic_wait_state: got %b expected 100", {mem_rd, drload, bus_mem_oe});
        end
        tick();  // LOAD
        compared++;
        if ({mem_rd, drload, bus_mem_oe, done} !== 5'b11100) begin
            mismatched++;
            $display("FAIL basic_load_state: got %b expected 11100", {mem_rd, drload, bus_mem_oe, done});
        end
        tick();  // DONE
        compared++;
        if ({done, err, drload, mem_rd, busy} !== 6'b010001) begin
            mismatched++;
            $display("FAIL basic_done_state: got %b expected 010001", {done, err, drload, mem_rd, busy});
        end
        compared++;
        if (dr !== 8'hA5) begin
            mismatched++;
            $display("FAIL basic_dr_value: got %h expected a5", dr);
        end
        tick();  // IDLE
        compared++;
        if ({gnt, done, busy} !== 5'b00000) begin
            mismatched++;
            $display("FAIL basic_back_idle: got %b expected 00000", {gnt, done, busy});
        end
    endtask

    // rr_ptr is 1 here (last owner was fetch), so a tie goes to execute.
    task automatic test_rst_mid();
        req = 2'b11; mem_rdy = 1'b0; bus_val = 16'h1177;
        tick();  // ADDR
        req = 2'b00;
        compared++;
        if (gnt !== 2'b10) begin
            mismatched++;
            $display("FAIL rstmid_first_gnt: got %b expected 10", gnt);
        end
        compared++;
        if (mem_addr !== 16'h0034) begin
            mismatched++;
            $display("FAIL rstmid_mem_addr: got %h expected 0034", mem_addr);
        end
        tick();  // WAIT
        tick();  // WAIT
        rst = 1'b1;
        #1;
        compared++;
        if ({gnt, done, err, busy, mem_rd, bus_mem_oe, drload} !== 9'b0) begin
            mismatched++;
            $display("FAIL rstmid_async_clear: got %b expected 000000000",
                     {gnt, done, err, busy, mem_rd, bus_mem_oe, drload});
        end
        #1;
        rst = 1'b0;
        tick();
        compared++;
        if ({busy, dr} !== {1'b0, 8'hA5}) begin
            mismatched++;
            $display("FAIL rstmid_idle_dr: got %h expected 0a5", {busy, dr});
        end
    endtask

    // Reset cleared rr_ptr, so with req held at 11 the grants go 01, 10, 01.
    task automatic test_round_robin();
        req = 2'b11; mem_rdy = 1'b1; bus_val = 16'h2200;
        tick();  // ADDR
        compared++;
        if (gnt !== 2'b01) begin
            mismatched++;
            $display("FAIL rr_grant1: got %b expected 01", gnt);
        end
        tick(); tick(); tick();  // DONE
        compared++;
        if (done !== 2'b01) begin
            mismatched++;
            $display("FAIL rr_done1: got %b expected 01", done);
        end
        tick();  // IDLE
        tick();  // ADDR
        compared++;
        if (gnt !== 2'b10) begin
            mismatched++;
            $display("FAIL rr_grant2: got %b expected 10", gnt);
        end
        tick(); tick(); tick();
        compared++;
        if (done !== 2'b10) begin
            mismatched++;
            $display("FAIL rr_done2: got %b expected 10", done);
        end
        tick();
        tick();
        compared++;
        if (gnt !== 2'b01) begin
            mismatched++;
            $display("FAIL rr_grant3: got %b expected 01", gnt);
        end
        req = 2'b00;
        tick(); tick(); tick(); tick();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rr_final_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_delayed_rdy();
        int n;
        int loads;
        req = 2'b01; mem_rdy = 1'b0; bus_val = 16'h1234;
        n = 1; loads = 0;
        tick();  // ADDR
        req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            n++;
            compared++;
            if ({mem_rd, drload} !== 2'b10) begin
                mismatched++;
                $display("FAIL delay_wait_%0d: got %b expected 10", i, {mem_rd, drload});
            end
        end
        mem_rdy = 1'b1;
        while (done === 2'b00 && n < 40) begin
            tick();
            n++;
            if (drload === 1'b1) loads++;
        end
        compared++;
        if (n !== 8) begin
            mismatched++;
            $display("FAIL delay_done_cycle: got %0d expected 8", n);
        end
        compared++;
        if ({done, err} !== 3'b010) begin
            mismatched++;
            $display("FAIL delay_done_err: got %b expected 010", {done, err});
        end
        compared++;
        if (loads !== 1) begin
            mismatched++;
            $display("FAIL delay_drload_count: got %0d expected 1", loads);
        end
        compared++;
        if (dr !== 8'h34) begin
            mismatched++;
            $display("FAIL delay_dr_value: got %h expected 34", dr);
        end
        tick();
    endtask

    // Last owner was fetch, so rr_ptr is 1 going in and must be 0 after.
    task automatic test_timeout();
        int n;
        int loads;
        req = 2'b10; mem_rdy = 1'b0; bus_val = 16'h5678;
        n = 0; loads = 0;
        tick();
        n++;
        req = 2'b00;
        while (done === 2'b00 && n < 40) begin
            tick();
            n++;
            if (drload === 1'b1 || bus_mem_oe === 1'b1) loads++;
        end
        compared++;
        if (n !== 17) begin
            mismatched++;
            $display("FAIL timeout_done_cycle: got %0d expected 17", n);
        end
        compared++;
        if ({done, err} !== 3'b101) begin
            mismatched++;
            $display("FAIL timeout_done_err: got %b expected 101", {done, err});
        end
        compared++;
        if (loads !== 0) begin
            mismatched++;
            $display("FAIL timeout_no_load: got %0d expected 0", loads);
        end
        compared++;
        if (dr !== 8'h34) begin
            mismatched++;
            $display("FAIL timeout_dr_kept: got %h expected 34", dr);
        end
        tick();
        compared++;
        if ({done, err, busy} !== 4'b0000) begin
            mismatched++;
            $display("FAIL timeout_cleared: got %b expected 0000", {done, err, busy});
        end
        req = 2'b11; mem_rdy = 1'b1;
        tick();
        req = 2'b00;
        compared++;
        if (gnt !== 2'b01) begin
            mismatched++;
            $display("FAIL timeout_rr_toggle: got %b expected 01", gnt);
        end
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_drop_req();
        int n;
        req = 2'b01; mem_rdy = 1'b0; bus_val = 16'h00C3;
        n = 0;
        tick();  // ADDR
        n++;
        tick();  // WAIT
        n++;
        req = 2'b00;
        tick();  // WAIT
        n++;
        mem_rdy = 1'b1;
        while (done === 2'b00 && n < 40) begin
            tick();
            n++;
        end
        compared++;
        if ({done, n} !== {2'b01, 32'd5}) begin
            mismatched++;
            $display("FAIL drop_done: got done=%b cycle=%0d expected done=01 cycle=5", done, n);
        end
        compared++;
        if (dr !== 8'hC3) begin
            mismatched++;
            $display("FAIL drop_dr_value: got %h expected c3", dr);
        end
        tick();
        tick();
        compared++;
        if ({busy, gnt} !== 3'b000) begin
            mismatched++;
            $display("FAIL drop_no_regrant: got %b expected 000", {busy, gnt});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rst_mid();
        test_round_robin();
        test_delayed_rdy();
        test_timeout();
        test_drop_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
